// File: rtl/filter_pkg.sv
// filter_pkg: shared types for rule_filter.
//   - FSM state encoding, rule_wr_field codes
//   - rule_t: one rule table entry; hdr_t: latched 4-tuple
//   - IP_ADDR_LEN / PORT_LEN: field widths used by rule_t / hdr_t
package filter_pkg;

    localparam int IP_ADDR_LEN = 32;
    localparam int PORT_LEN    = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_MATCH,
        S_WAIT_FOR_CLEAR
    } state_t;

    typedef enum logic [2:0] {
        FLD_SRC_IP   = 3'd0,
        FLD_SRC_MASK = 3'd1,
        FLD_DST_IP   = 3'd2,
        FLD_DST_MASK = 3'd3,
        FLD_SRC_PORT = 3'd4,
        FLD_DST_PORT = 3'd5,
        FLD_CTRL     = 3'd6
    } field_t;

    typedef struct packed {
        logic [IP_ADDR_LEN-1:0] src_ip;
        logic [IP_ADDR_LEN-1:0] src_mask;
        logic [IP_ADDR_LEN-1:0] dst_ip;
        logic [IP_ADDR_LEN-1:0] dst_mask;
        logic [PORT_LEN-1:0]    src_port;
        logic [PORT_LEN-1:0]    dst_port;
        logic                   action;   // 1 = send
        logic                   enable;
    } rule_t;

    typedef struct packed {
        logic [IP_ADDR_LEN-1:0] src_ip;
        logic [IP_ADDR_LEN-1:0] dst_ip;
        logic [PORT_LEN-1:0]    src_port;
        logic [PORT_LEN-1:0]    dst_port;
    } hdr_t;

endpackage

// File: rtl/rule_match.sv
// rule_match: compares one rule against the latched header.
//   rule_i  : rule table entry
//   hdr_i   : latched header 4-tuple
//   match_o : 1 when the rule is enabled and every field matches
// A rule port of 0 is a wildcard; IPs are compared under their masks.
module rule_match
    import filter_pkg::*;
(
    input  rule_t rule_i,
    input  hdr_t  hdr_i,
    output logic  match_o
);

    logic src_ok, dst_ok, sport_ok, dport_ok;

    assign src_ok   = (hdr_i.src_ip & rule_i.src_mask) == (rule_i.src_ip & rule_i.src_mask);
    assign dst_ok   = (hdr_i.dst_ip & rule_i.dst_mask) == (rule_i.dst_ip & rule_i.dst_mask);
    assign sport_ok = (rule_i.src_port == '0) || (rule_i.src_port == hdr_i.src_port);
    assign dport_ok = (rule_i.dst_port == '0) || (rule_i.dst_port == hdr_i.dst_port);
    assign match_o  = rule_i.enable && src_ok && dst_ok && sport_ok && dport_ok;

endmodule

// File: rtl/rule_filter.sv
// rule_filter: multi-rule masked header filter with fixed priority.
//   axi_aclk / axi_areset      : clock, synchronous active-high reset
//   hdr_rd / hdr_clear         : header valid pulse / packet-done release
//   hdr_{src,dst}_{ip,port}    : parsed 4-tuple
//   rule_wr_*                  : rule table write port (field codes in filter_pkg)
//   m_send / m_send_rd         : forward decision / decision valid until hdr_clear
//   m_rule_hit / m_rule_idx    : winning rule (lowest index), idx 0 on miss
//   cnt_rd_idx / cnt_rd_data   : hit counter read (NUM_RULES selects default counter)
// Optional feature macro: RULE_HIT_COUNTERS_EN enables saturating hit counters;
// without it cnt_rd_data reads 0.
module rule_filter #(
    parameter int NUM_RULES      = 8,
    parameter int IP_ADDR_LEN    = filter_pkg::IP_ADDR_LEN,
    parameter int PORT_LEN       = filter_pkg::PORT_LEN,
    parameter bit DEFAULT_PERMIT = 1'b0,
    localparam int IDX_W         = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
    input  logic                   axi_aclk,
    input  logic                   axi_areset,
    input  logic                   hdr_rd,
    input  logic                   hdr_clear,
    input  logic [IP_ADDR_LEN-1:0] hdr_src_ip,
    input  logic [IP_ADDR_LEN-1:0] hdr_dst_ip,
    input  logic [PORT_LEN-1:0]    hdr_src_port,
    input  logic [PORT_LEN-1:0]    hdr_dst_port,
    input  logic                   rule_wr_en,
    input  logic [IDX_W-1:0]       rule_wr_idx,
    input  logic [2:0]             rule_wr_field,
    input  logic [31:0]            rule_wr_data,
    output logic                   m_send,
    output logic                   m_send_rd,
    output logic                   m_rule_hit,
    output logic [IDX_W-1:0]       m_rule_idx,
    input  logic [IDX_W:0]         cnt_rd_idx,
    output logic [31:0]            cnt_rd_data
);
    import filter_pkg::*;

    state_t               state_q;
    hdr_t                 hdr_q;
    rule_t                rules_q [NUM_RULES];
    logic [NUM_RULES-1:0] match_vec;
    logic [NUM_RULES-1:0] match_q;
    logic [NUM_RULES-1:0] act_q;
    logic                 hit;
    logic [IDX_W-1:0]     win;

    // Rule table: writes land on the next edge regardless of FSM state.
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            for (int i = 0; i < NUM_RULES; i++) rules_q[i] <= '0;
        end else if (rule_wr_en) begin
            for (int i = 0; i < NUM_RULES; i++) begin
                if (rule_wr_idx == IDX_W'(i)) begin
                    case (rule_wr_field)
                        FLD_SRC_IP:   rules_q[i].src_ip   <= rule_wr_data[IP_ADDR_LEN-1:0];
                        FLD_SRC_MASK: rules_q[i].src_mask <= rule_wr_data[IP_ADDR_LEN-1:0];
                        FLD_DST_IP:   rules_q[i].dst_ip   <= rule_wr_data[IP_ADDR_LEN-1:0];
                        FLD_DST_MASK: rules_q[i].dst_mask <= rule_wr_data[IP_ADDR_LEN-1:0];
                        FLD_SRC_PORT: rules_q[i].src_port <= rule_wr_data[PORT_LEN-1:0];
                        FLD_DST_PORT: rules_q[i].dst_port <= rule_wr_data[PORT_LEN-1:0];
                        FLD_CTRL: begin
                            rules_q[i].action <= rule_wr_data[1];
                            rules_q[i].enable <= rule_wr_data[0];
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_RULES; g++) begin : g_rule
        rule_match u_match (
            .rule_i  (rules_q[g]),
            .hdr_i   (hdr_q),
            .match_o (match_vec[g])
        );
    end

    // Lowest index wins: scan downward so the last assignment is the smallest index.
    always_comb begin
        hit = 1'b0;
        win = '0;
        for (int i = NUM_RULES - 1; i >= 0; i--) begin
            if (match_q[i]) begin
                hit = 1'b1;
                win = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state_q    <= S_IDLE;
            hdr_q      <= '0;
            match_q    <= '0;
            act_q      <= '0;
            m_send     <= 1'b0;
            m_send_rd  <= 1'b0;
            m_rule_hit <= 1'b0;
            m_rule_idx <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    m_send     <= 1'b0;
                    m_send_rd  <= 1'b0;
                    m_rule_hit <= 1'b0;
                    m_rule_idx <= '0;
                    if (hdr_rd) begin
                        hdr_q   <= '{src_ip: hdr_src_ip, dst_ip: hdr_dst_ip,
                                     src_port: hdr_src_port, dst_port: hdr_dst_port};
                        state_q <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    // Snapshot actions together with matches so a table write
                    // during MATCH cannot split the decision across two table versions.
                    match_q <= match_vec;
                    for (int i = 0; i < NUM_RULES; i++) act_q[i] <= rules_q[i].action;
                    state_q <= S_MATCH;
                end
                S_MATCH: begin
                    m_send     <= hit ? act_q[win] : DEFAULT_PERMIT;
                    m_rule_hit <= hit;
                    m_rule_idx <= win;
                    m_send_rd  <= 1'b1;
                    state_q    <= S_WAIT_FOR_CLEAR;
                end
                S_WAIT_FOR_CLEAR: begin
                    if (hdr_clear) begin
                        m_send     <= 1'b0;
                        m_send_rd  <= 1'b0;
                        m_rule_hit <= 1'b0;
                        m_rule_idx <= '0;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef RULE_HIT_COUNTERS_EN
    logic [31:0]        cnt_q [NUM_RULES+1];
    logic [NUM_RULES:0] cnt_sel;

    // Slot NUM_RULES counts default (no-hit) decisions.
    always_comb begin
        cnt_sel = '0;
        for (int i = 0; i < NUM_RULES; i++) cnt_sel[i] = hit && (win == IDX_W'(i));
        cnt_sel[NUM_RULES] = !hit;
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            for (int i = 0; i <= NUM_RULES; i++) cnt_q[i] <= '0;
        end else if (state_q == S_MATCH) begin
            for (int i = 0; i <= NUM_RULES; i++) begin
                if (cnt_sel[i] && (cnt_q[i] != 32'hFFFF_FFFF)) cnt_q[i] <= cnt_q[i] + 32'd1;
            end
        end
    end

    always_comb begin
        cnt_rd_data = '0;
        for (int i = 0; i <= NUM_RULES; i++) begin
            if (cnt_rd_idx == (IDX_W+1)'(i)) cnt_rd_data = cnt_q[i];
        end
    end
`else
    logic unused_cnt;
    assign unused_cnt  = ^cnt_rd_idx;
    assign cnt_rd_data = '0;
`endif

endmodule

// File: tb/tb_rule_filter.sv
module tb_rule_filter;
    localparam int NR    = 8;
    localparam int IDX_W = 3;
    localparam bit DEF   = 1'b0;

    logic              axi_aclk = 1'b0;
    logic              axi_areset = 1'b1;
    logic              hdr_rd = 1'b0, hdr_clear = 1'b0;
    logic [31:0]       hdr_src_ip = '0, hdr_dst_ip = '0;
    logic [15:0]       hdr_src_port = '0, hdr_dst_port = '0;
    logic              rule_wr_en = 1'b0;
    logic [IDX_W-1:0]  rule_wr_idx = '0;
    logic [2:0]        rule_wr_field = '0;
    logic [31:0]       rule_wr_data = '0;
    logic              m_send, m_send_rd, m_rule_hit;
    logic [IDX_W-1:0]  m_rule_idx;
    logic [IDX_W:0]    cnt_rd_idx = '0;
    logic [31:0]       cnt_rd_data;

    int vectors = 0;
    int miscompares = 0;

    // Reference rule table
    logic [31:0] m_sip [NR], m_smask [NR], m_dip [NR], m_dmask [NR];
    logic [15:0] m_sport [NR], m_dport [NR];
    bit          m_act [NR], m_en [NR];

    rule_filter #(.NUM_RULES(NR), .IP_ADDR_LEN(32), .PORT_LEN(16), .DEFAULT_PERMIT(DEF)) dut (
        .axi_aclk(axi_aclk), .axi_areset(axi_areset),
        .hdr_rd(hdr_rd), .hdr_clear(hdr_clear),
        .hdr_src_ip(hdr_src_ip), .hdr_dst_ip(hdr_dst_ip),
        .hdr_src_port(hdr_src_port), .hdr_dst_port(hdr_dst_port),
        .rule_wr_en(rule_wr_en), .rule_wr_idx(rule_wr_idx),
        .rule_wr_field(rule_wr_field), .rule_wr_data(rule_wr_data),
        .m_send(m_send), .m_send_rd(m_send_rd), .m_rule_hit(m_rule_hit), .m_rule_idx(m_rule_idx),
        .cnt_rd_idx(cnt_rd_idx), .cnt_rd_data(cnt_rd_data)
    );

    always #5 axi_aclk = ~axi_aclk;

    function automatic void model_clear();
        for (int r = 0; r < NR; r++) begin
            m_sip[r] = '0; m_smask[r] = '0; m_dip[r] = '0; m_dmask[r] = '0;
            m_sport[r] = '0; m_dport[r] = '0; m_act[r] = 1'b0; m_en[r] = 1'b0;
        end
    endfunction

    // First enabled rule whose masked IPs agree (no differing bit under the mask)
    // and whose ports are wildcard or equal decides; otherwise the default.
    function automatic void model(input logic [31:0] s, d, input logic [15:0] sp, dp,
                                  output logic send, output logic hit, output logic [IDX_W-1:0] idx);
        send = DEF; hit = 1'b0; idx = '0;
        for (int r = 0; r < NR; r++) begin
            if (!hit && m_en[r] && (((s ^ m_sip[r]) & m_smask[r]) == 0) &&
                (((d ^ m_dip[r]) & m_dmask[r]) == 0) &&
                (m_sport[r] == 0 || m_sport[r] == sp) && (m_dport[r] == 0 || m_dport[r] == dp)) begin
                hit = 1'b1; idx = IDX_W'(r); send = m_act[r];
            end
        end
    endfunction

    task automatic do_reset();
        @(negedge axi_aclk); axi_areset = 1'b1;
        repeat (2) @(posedge axi_aclk);
        @(negedge axi_aclk); axi_areset = 1'b0;
        model_clear();
    endtask

    task automatic write_rule(input int idx, input int field, input logic [31:0] data);
        @(negedge axi_aclk);
        rule_wr_en = 1'b1; rule_wr_idx = IDX_W'(idx); rule_wr_field = 3'(field); rule_wr_data = data;
        @(posedge axi_aclk); #1 rule_wr_en = 1'b0;
        case (field)
            0: m_sip[idx] = data;
            1: m_smask[idx] = data;
            2: m_dip[idx] = data;
            3: m_dmask[idx] = data;
            4: m_sport[idx] = data[15:0];
            5: m_dport[idx] = data[15:0];
            6: begin m_act[idx] = data[1]; m_en[idx] = data[0]; end
            default: ;
        endcase
    endtask

    // Drives one header, measures edges until m_send_rd, samples the decision and,
    // if asked, clears in the first decision cycle and samples m_send_rd after.
    task automatic send_packet(input logic [31:0] s, d, input logic [15:0] sp, dp, input bit do_clear,
                               output int lat, output logic o_send, o_hit,
                               output logic [IDX_W-1:0] o_idx, output logic rd_after);
        @(negedge axi_aclk);
        hdr_src_ip = s; hdr_dst_ip = d; hdr_src_port = sp; hdr_dst_port = dp; hdr_rd = 1'b1;
        @(posedge axi_aclk); #1 hdr_rd = 1'b0;
        lat = -1;
        for (int c = 0; c < 10; c++) begin
            if (m_send_rd === 1'b1) begin lat = c; break; end
            @(posedge axi_aclk); #1;
        end
        o_send = m_send; o_hit = m_rule_hit; o_idx = m_rule_idx;
        if (do_clear) begin
            hdr_clear = 1'b1;
            @(posedge axi_aclk); #1 hdr_clear = 1'b0;
        end
        rd_after = m_send_rd;
    endtask

    task automatic test_reset();
        @(posedge axi_aclk); #1;
        vectors++; if (m_send_rd !== 1'b0) begin miscompares++; $display("FAIL reset_send_rd got %b want 0", m_send_rd); end
        vectors++; if (m_send !== 1'b0) begin miscompares++; $display("FAIL reset_send got %b want 0", m_send); end
        vectors++; if (m_rule_hit !== 1'b0) begin miscompares++; $display("FAIL reset_hit got %b want 0", m_rule_hit); end
        vectors++; if (m_rule_idx !== '0) begin miscompares++; $display("FAIL reset_idx got %0d want 0", m_rule_idx); end
        vectors++; if (cnt_rd_data !== 32'd0) begin miscompares++; $display("FAIL reset_cnt got %0d want 0", cnt_rd_data); end
        @(negedge axi_aclk); axi_areset = 1'b0;
        model_clear();
    endtask

    task automatic test_empty_table();
        int lat; logic s, h, ra; logic [IDX_W-1:0] ix;
        send_packet(32'hAAAA_AAAA, 32'h1234_5678, 16'd1000, 16'd80, 1'b1, lat, s, h, ix, ra);
        vectors++; if (lat !== 2) begin miscompares++; $display("FAIL empty_latency got %0d want 2", lat); end
        vectors++; if (s !== DEF) begin miscompares++; $display("FAIL empty_send got %b want %b", s, DEF); end
        vectors++; if (h !== 1'b0) begin miscompares++; $display("FAIL empty_hit got %b want 0", h); end
        vectors++; if (ra !== 1'b0) begin miscompares++; $display("FAIL empty_clear got %b want 0", ra); end
    endtask

    task automatic test_prefix_rule();
        logic [31:0] srcs [2];
        srcs[0] = 32'h0A01_0203; srcs[1] = 32'h0B01_0203;
        write_rule(2, 0, 32'h0A00_0000);
        write_rule(2, 1, 32'hFF00_0000);
        write_rule(2, 6, 32'd3);
        for (int k = 0; k < 2; k++) begin
            int lat; logic s, h, ra, es, eh; logic [IDX_W-1:0] ix, ei;
            model(srcs[k], 32'h0, 16'd5, 16'd6, es, eh, ei);
            send_packet(srcs[k], 32'h0, 16'd5, 16'd6, 1'b1, lat, s, h, ix, ra);
            vectors++; if (lat !== 2 || s !== es || h !== eh || ix !== ei || ra !== 1'b0) begin
                miscompares++;
                $display("FAIL prefix_%0d got lat=%0d send=%b hit=%b idx=%0d rd_after=%b want lat=2 send=%b hit=%b idx=%0d rd_after=0",
                         k, lat, s, h, ix, ra, es, eh, ei);
            end
        end
    endtask

    task automatic test_priority_ports();
        logic [31:0] srcs [3]; logic [15:0] dps [3];
        srcs[0] = 32'h0B00_0001; dps[0] = 16'd80;
        srcs[1] = 32'h0B00_0001; dps[1] = 16'd443;
        srcs[2] = 32'h0A00_0005; dps[2] = 16'd443;
        write_rule(1, 5, 32'd80);
        write_rule(1, 6, 32'd1);
        write_rule(3, 6, 32'd3);
        for (int k = 0; k < 3; k++) begin
            int lat; logic s, h, ra, es, eh; logic [IDX_W-1:0] ix, ei;
            model(srcs[k], 32'h0C00_0000, 16'd999, dps[k], es, eh, ei);
            send_packet(srcs[k], 32'h0C00_0000, 16'd999, dps[k], 1'b1, lat, s, h, ix, ra);
            vectors++; if (lat !== 2 || s !== es || h !== eh || ix !== ei || ra !== 1'b0) begin
                miscompares++;
                $display("FAIL priority_%0d got lat=%0d send=%b hit=%b idx=%0d rd_after=%b want lat=2 send=%b hit=%b idx=%0d rd_after=0",
                         k, lat, s, h, ix, ra, es, eh, ei);
            end
        end
    endtask

    task automatic test_ignore_in_wait();
        int lat; logic s, h, ra, es, eh; logic [IDX_W-1:0] ix, ei;
        model(32'h0102_0304, 32'h0, 16'd7, 16'd443, es, eh, ei);
        send_packet(32'h0102_0304, 32'h0, 16'd7, 16'd443, 1'b0, lat, s, h, ix, ra);
        vectors++; if (s !== es || ix !== ei || h !== eh) begin miscompares++;
            $display("FAIL wait_first got send=%b hit=%b idx=%0d want send=%b hit=%b idx=%0d", s, h, ix, es, eh, ei); end
        hdr_dst_port = 16'd80; hdr_rd = 1'b1;
        repeat (4) @(posedge axi_aclk);
        #1 hdr_rd = 1'b0;
        vectors++; if (m_send_rd !== 1'b1 || m_send !== es || m_rule_hit !== eh || m_rule_idx !== ei) begin
            miscompares++;
            $display("FAIL wait_hold got rd=%b send=%b hit=%b idx=%0d want rd=1 send=%b hit=%b idx=%0d",
                     m_send_rd, m_send, m_rule_hit, m_rule_idx, es, eh, ei);
        end
        hdr_clear = 1'b1;
        @(posedge axi_aclk); #1 hdr_clear = 1'b0;
        vectors++; if (m_send_rd !== 1'b0 || m_send !== 1'b0 || m_rule_hit !== 1'b0 || m_rule_idx !== '0) begin
            miscompares++;
            $display("FAIL wait_clear got rd=%b send=%b hit=%b idx=%0d want all 0", m_send_rd, m_send, m_rule_hit, m_rule_idx);
        end
        // Back-to-back: next header accepted right after the clear
        model(32'h0102_0304, 32'h0, 16'd7, 16'd80, es, eh, ei);
        send_packet(32'h0102_0304, 32'h0, 16'd7, 16'd80, 1'b1, lat, s, h, ix, ra);
        vectors++; if (lat !== 2 || s !== es || h !== eh || ix !== ei || ra !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_back got lat=%0d send=%b hit=%b idx=%0d want lat=2 send=%b hit=%b idx=%0d",
                     lat, s, h, ix, es, eh, ei);
        end
    endtask

    task automatic test_random();
        logic [31:0] masks [4]; logic [15:0] ports [4];
        masks[0] = 32'h0; masks[1] = 32'hFF00_0000; masks[2] = 32'hFFFF_0000; masks[3] = 32'hFFFF_FFFF;
        ports[0] = 16'd80; ports[1] = 16'd443; ports[2] = 16'd22; ports[3] = 16'd53;
        for (int r = 0; r < NR; r++) begin
            write_rule(r, 0, $urandom);
            write_rule(r, 1, masks[$urandom_range(0, 3)]);
            write_rule(r, 2, $urandom);
            write_rule(r, 3, masks[$urandom_range(0, 3)]);
            write_rule(r, 4, ($urandom_range(0, 2) == 0) ? 32'(ports[$urandom_range(0, 3)]) : 32'd0);
            write_rule(r, 5, ($urandom_range(0, 1) == 0) ? 32'(ports[$urandom_range(0, 3)]) : 32'd0);
            write_rule(r, 6, 32'($urandom_range(0, 3)) | 32'($urandom_range(0, 1)));
        end
        for (int k = 0; k < 40; k++) begin
            int lat, r; logic s, h, ra, es, eh; logic [IDX_W-1:0] ix, ei;
            logic [31:0] sa, da; logic [15:0] sp, dp;
            r  = $urandom_range(0, NR - 1);
            sa = ($urandom_range(0, 3) == 0) ? $urandom : (m_sip[r] ^ ($urandom & 32'h0000_FFFF));
            da = ($urandom_range(0, 3) == 0) ? $urandom : (m_dip[r] ^ ($urandom & 32'h0000_00FF));
            sp = ports[$urandom_range(0, 3)];
            dp = ports[$urandom_range(0, 3)];
            model(sa, da, sp, dp, es, eh, ei);
            send_packet(sa, da, sp, dp, 1'b1, lat, s, h, ix, ra);
            vectors++; if (lat !== 2 || s !== es || h !== eh || ix !== ei || ra !== 1'b0) begin
                miscompares++;
                $display("FAIL random_%0d got lat=%0d send=%b hit=%b idx=%0d rd_after=%b want lat=2 send=%b hit=%b idx=%0d rd_after=0",
                         k, lat, s, h, ix, ra, es, eh, ei);
            end
        end
    endtask

    task automatic test_reset_mid_lookup();
        int lat; logic s, h, ra; logic [IDX_W-1:0] ix;
        write_rule(0, 6, 32'd3);  // rule 0 permits everything (masks/ports already cleared or random)
        write_rule(0, 1, 32'd0); write_rule(0, 3, 32'd0); write_rule(0, 4, 32'd0); write_rule(0, 5, 32'd0);
        @(negedge axi_aclk);
        hdr_src_ip = $urandom; hdr_rd = 1'b1;
        @(posedge axi_aclk); #1 hdr_rd = 1'b0; axi_areset = 1'b1;   // now in LATCH
        @(posedge axi_aclk); #1 axi_areset = 1'b0;
        model_clear();
        vectors++; if (m_send_rd !== 1'b0 || m_send !== 1'b0 || m_rule_hit !== 1'b0 || m_rule_idx !== '0) begin
            miscompares++;
            $display("FAIL midreset_out got rd=%b send=%b hit=%b idx=%0d want all 0", m_send_rd, m_send, m_rule_hit, m_rule_idx);
        end
        repeat (3) @(posedge axi_aclk);
        #1;
        vectors++; if (m_send_rd !== 1'b0) begin miscompares++; $display("FAIL midreset_abandon got rd=%b want 0", m_send_rd); end
        send_packet(32'h0A0B_0C0D, 32'h1, 16'd1, 16'd2, 1'b1, lat, s, h, ix, ra);
        vectors++; if (lat !== 2 || s !== DEF || h !== 1'b0 || ix !== '0) begin
            miscompares++;
            $display("FAIL midreset_fresh got lat=%0d send=%b hit=%b idx=%0d want lat=2 send=%b hit=0 idx=0", lat, s, h, ix, DEF);
        end
    endtask

    task automatic test_counters();
        int lat; logic s, h, ra; logic [IDX_W-1:0] ix;
`ifdef RULE_HIT_COUNTERS_EN
        int exp_hit = 0, exp_def = 0;
        do_reset();
        write_rule(0, 6, 32'd3);
        for (int k = 0; k < 5; k++) begin
            send_packet($urandom, $urandom, 16'(k), 16'(k + 1), 1'b1, lat, s, h, ix, ra);
            exp_hit++;
        end
        write_rule(0, 6, 32'd0);
        for (int k = 0; k < 2; k++) begin
            send_packet($urandom, $urandom, 16'd3, 16'd4, 1'b1, lat, s, h, ix, ra);
            exp_def++;
        end
        cnt_rd_idx = 4'd0; #1;
        vectors++; if (cnt_rd_data !== 32'(exp_hit)) begin miscompares++; $display("FAIL cnt_rule0 got %0d want %0d", cnt_rd_data, exp_hit); end
        cnt_rd_idx = 4'(NR); #1;
        vectors++; if (cnt_rd_data !== 32'(exp_def)) begin miscompares++; $display("FAIL cnt_default got %0d want %0d", cnt_rd_data, exp_def); end
        cnt_rd_idx = 4'd1; #1;
        vectors++; if (cnt_rd_data !== 32'd0) begin miscompares++; $display("FAIL cnt_rule1 got %0d want 0", cnt_rd_data); end
        cnt_rd_idx = 4'(NR + 1); #1;
        vectors++; if (cnt_rd_data !== 32'd0) begin miscompares++; $display("FAIL cnt_beyond got %0d want 0", cnt_rd_data); end
`else
        send_packet($urandom, $urandom, 16'd3, 16'd4, 1'b1, lat, s, h, ix, ra);
        for (int k = 0; k <= NR; k++) begin
            cnt_rd_idx = 4'(k); #1;
            vectors++; if (cnt_rd_data !== 32'd0) begin miscompares++; $display("FAIL cnt_off_%0d got %0d want 0", k, cnt_rd_data); end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_empty_table();
        test_prefix_rule();
        test_priority_ports();
        test_ignore_in_wait();
        test_random();
        test_reset_mid_lookup();
        test_counters();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
